// File: rtl/fib_pkg.sv
// fib_pkg: shared types and helpers for the Fibonacci display path.
//   fib_bcd_state_t  : converter FSM states (IDLE, SHIFT, DONE)
//   bcd_digit_t      : one unsigned packed BCD digit
//   fib_bcd_digits() : number of BCD digits needed for a bW-bit binary value
package fib_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } fib_bcd_state_t;

  typedef logic [3:0] bcd_digit_t;

  // log10(2) ~= 0.30103, so this gives the decimal digit count of 2^bw - 1.
  function automatic int fib_bcd_digits(input int bw);
    return (bw * 30103) / 100000 + 1;
  endfunction

endpackage

// File: rtl/fib_bcd_digit.sv
// fib_bcd_digit: combinational double-dabble digit adjust.
//   i_digit : current BCD digit of the accumulator
//   o_digit : digit after the "if >= 5 then +3" correction (max 4'b1100)
module fib_bcd_digit
  import fib_pkg::*;
(
  input  bcd_digit_t i_digit,
  output bcd_digit_t o_digit
);

  assign o_digit = (i_digit >= 4'd5) ? bcd_digit_t'(i_digit + 4'd3) : i_digit;

endmodule

// File: rtl/fib_bcd.sv
// fib_bcd: sequential binary-to-BCD converter (shift-and-add-3, one bit per
// cycle) sitting downstream of the Fibonacci generator.
// Optional feature macro: FIB_BCD_WRAP_EN -- when defined, wrap flags a result
// whose input was smaller than the previously accepted input.
// Ports:
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset
//   in_data   : bW-bit binary value to convert
//   in_valid  : in_data valid
//   in_ready  : converter idle and able to accept
//   bcd       : packed BCD result, digit 0 in bits [3:0]
//   out_valid : bcd/wrap valid
//   out_ready : consumer takes the result
//   wrap      : input was below the previous accepted input (0 if compiled out)
module fib_bcd
  import fib_pkg::*;
#(
  parameter int bW = 3
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [bW-1:0]                        in_data,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  output logic [4*fib_bcd_digits(bW)-1:0]      bcd,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 wrap
);

  localparam int ND = fib_bcd_digits(bW);
  localparam int AW = 4 * ND;
  localparam int CW = $clog2(bW + 1);

  fib_bcd_state_t r_state;
  logic [bW-1:0]  r_shift;
  logic [AW-1:0]  r_acc;
  logic [AW-1:0]  r_bcd;
  logic [CW-1:0]  r_cnt;
  logic           r_out_valid;

  logic [AW-1:0]  w_adj;
  logic [AW-1:0]  w_acc_nxt;
  logic           w_accept;
  logic           w_last;
  logic           w_unused_msb;

  // Per-digit add-3 correction applied to the whole accumulator in parallel.
  for (genvar g = 0; g < ND; g++) begin : g_digit
    fib_bcd_digit u_digit (
      .i_digit (r_acc[4*g +: 4]),
      .o_digit (w_adj[4*g +: 4])
    );
  end

  // The top accumulator bit shifts out; ND is sized so it is always 0.
  assign w_acc_nxt    = {w_adj[AW-2:0], r_shift[bW-1]};
  assign w_unused_msb = w_adj[AW-1];

  assign w_accept = (r_state == IDLE) && in_valid;
  assign w_last   = (r_state == SHIFT) && (r_cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_acc       <= '0;
      r_bcd       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_shift <= in_data;
            r_acc   <= '0;
            r_cnt   <= CW'(bW);
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_acc   <= w_acc_nxt;
          r_shift <= r_shift << 1;
          r_cnt   <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_bcd       <= w_acc_nxt;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_out_valid;
  assign bcd       = r_bcd;

`ifdef FIB_BCD_WRAP_EN
  logic [bW-1:0] r_prev;
  logic          r_wrap_acc;
  logic          r_wrap;

  // The comparison is taken at acceptance, then moved to the output together
  // with the finished bcd so the pair always belongs to the same input.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev     <= '0;
      r_wrap_acc <= 1'b0;
      r_wrap     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_prev     <= in_data;
        r_wrap_acc <= (in_data < r_prev);
      end
      if (w_last) begin
        r_wrap <= r_wrap_acc;
      end
    end
  end

  assign wrap = r_wrap;
`else
  logic w_unused_ctl;
  assign w_unused_ctl = w_accept ^ w_last;
  assign wrap         = 1'b0;
`endif

endmodule

// File: tb/tb_fib_bcd.sv
module tb_fib_bcd;

`ifdef FIB_BCD_WRAP_EN
  localparam logic WRAP_ON = 1'b1;
`else
  localparam logic WRAP_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  logic [3:0]  in_data4;
  logic        in_valid4, in_ready4, out_valid4, out_ready4, wrap4;
  logic [7:0]  bcd4;

  logic [7:0]  in_data8;
  logic        in_valid8, in_ready8, out_valid8, out_ready8, wrap8;
  logic [11:0] bcd8;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  fib_bcd #(.bW(4)) u_dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data4),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .bcd       (bcd4),
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .wrap      (wrap4)
  );

  fib_bcd #(.bW(8)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data8),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .bcd       (bcd8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .wrap      (wrap8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Convert one value with out_ready held high from before acceptance, so
  // the handshake lands on the first DONE edge.
  task automatic conv(input int w, input logic [7:0] v, input logic [11:0] e,
                      input logic ew, input string tag);
    int lat;
    if (w == 4) out_ready4 = 1'b1; else out_ready8 = 1'b1;
    lat = 0;
    while (!((w == 4) ? in_ready4 : in_ready8) && lat < 30) begin
      tick();
      lat++;
    end
    check({tag, "_rdy"}, {31'd0, (w == 4) ? in_ready4 : in_ready8}, 32'd1);
    if (w == 4) begin in_data4 = v[3:0]; in_valid4 = 1'b1; end
    else        begin in_data8 = v;      in_valid8 = 1'b1; end
    tick();
    // Input need not stay stable after acceptance.
    if (w == 4) begin in_valid4 = 1'b0; in_data4 = 4'hf; end
    else        begin in_valid8 = 1'b0; in_data8 = 8'hff; end
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!((w == 4) ? out_valid4 : out_valid8) && lat < 40);
    check({tag, "_lat"}, lat, w);
    check({tag, "_bcd"}, (w == 4) ? {24'd0, bcd4} : {20'd0, bcd8}, {20'd0, e});
    check({tag, "_wrap"}, {31'd0, (w == 4) ? wrap4 : wrap8}, {31'd0, ew});
    tick();
    check({tag, "_idle"}, {30'd0, (w == 4) ? {in_ready4, out_valid4} : {in_ready8, out_valid8}},
          32'd2);
  endtask

  logic [7:0]  fib_v [13] = '{8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13, 8'd21,
                               8'd34, 8'd55, 8'd89, 8'd144, 8'd233};
  logic [11:0] fib_e [13] = '{12'h001, 12'h001, 12'h002, 12'h003, 12'h005, 12'h008,
                               12'h013, 12'h021, 12'h034, 12'h055, 12'h089, 12'h144,
                               12'h233};

  initial begin
    int lat;
    int seen;
    rst = 1'b1;
    in_data4 = '0; in_valid4 = 1'b0; out_ready4 = 1'b0;
    in_data8 = '0; in_valid8 = 1'b0; out_ready8 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    check("rst4_ready", {31'd0, in_ready4}, 32'd1);
    check("rst4_valid", {31'd0, out_valid4}, 32'd0);
    check("rst4_bcd", {24'd0, bcd4}, 32'h00);
    check("rst4_wrap", {31'd0, wrap4}, 32'd0);
    check("rst8_ready", {31'd0, in_ready8}, 32'd1);
    check("rst8_bcd", {20'd0, bcd8}, 32'h000);

    conv(4, 8'd13, 12'h013, 1'b0, "d4_13");
    conv(4, 8'd0,  12'h000, WRAP_ON, "d4_0");
    conv(4, 8'd15, 12'h015, 1'b0, "d4_15");

    pulse_rst();
    conv(4, 8'd8,  12'h008, 1'b0, "wrap_8");
    conv(4, 8'd13, 12'h013, 1'b0, "wrap_13");
    conv(4, 8'd5,  12'h005, WRAP_ON, "wrap_5");

    for (int i = 0; i < 13; i++) begin
      conv(8, fib_v[i], fib_e[i], 1'b0, $sformatf("fib%0d", i));
    end

    // Backpressure on 144 with stray in_valid pulses.
    pulse_rst();
    out_ready8 = 1'b0;
    in_data8 = 8'd144;
    in_valid8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!out_valid8 && lat < 40);
    check("bp_lat", lat, 8);
    for (int i = 0; i < 5; i++) begin
      in_data8 = 8'd7;
      in_valid8 = 1'b1;
      tick();
      in_valid8 = 1'b0;
      check($sformatf("bp_hold%0d", i), {19'd0, out_valid8, in_ready8, bcd8},
            {19'd0, 1'b1, 1'b0, 12'h144});
    end
    check("bp_wrap", {31'd0, wrap8}, 32'd0);
    out_ready8 = 1'b1;
    tick();
    out_ready8 = 1'b0;
    check("bp_release", {30'd0, in_ready8, out_valid8}, 32'd2);
    seen = 0;
    repeat (4) begin
      tick();
      if (out_valid8 || !in_ready8) seen++;
    end
    check("bp_no_stray", seen, 0);

    // Reset two cycles into a conversion of 200.
    in_data8 = 8'd200;
    in_valid8 = 1'b1;
    out_ready8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_state", {18'd0, in_ready8, out_valid8, bcd8}, {18'd0, 1'b1, 1'b0, 12'h000});
    seen = 0;
    repeat (12) begin
      tick();
      if (out_valid8) seen++;
    end
    check("mid_rst_no_out", seen, 0);
    conv(8, 8'd55, 12'h055, 1'b0, "after_rst55");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fib_bcd.md
# fib_bcd

Sequential binary-to-BCD converter placed directly downstream of the Fibonacci generator. It accepts one bW-bit binary value per valid/ready handshake and converts it with a shift-and-add-3 (double-dabble) engine, one bit per cycle. It presents packed BCD digits for the board's seven-segment display driver. An optional flag marks results whose input was smaller than the previously accepted input, which signals generator overflow.

## Interface
- bW, default 3: input value width; any value ≥ 1.
- ND, localparam = (bW*30103)/100000 + 1: number of BCD digits; always enough to hold 2^bW−1.
- Clocking: one clock; reset is synchronous and active-high.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_data  input  bW  binary value to convert, normally the generator's fibnum.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  converter can accept; equals (state == IDLE).
- bcd  output  4*ND  packed BCD result, digit 0 in bits [3:0].
- out_valid  output  1  bcd (and wrap) are valid.
- out_ready  input  1  consumer takes the result.
- wrap  output  1  the result's input was less than the previously accepted input; tied 0 when the feature is compiled out.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch in_data into the shift register, clear the BCD accumulator, load the bit counter with bW, go to SHIFT.
- SHIFT, one step per cycle:
  - Every digit ≥5 gets +3 (all digits in parallel).
  - Then shift {accumulator, shift register} left by 1, with the shift register's MSB entering accumulator bit 0.
  - Decrement the counter. When the counter reaches 0 after this step, go to DONE.
- DONE:
  - out_valid=1; bcd holds the accumulator, stable until accepted.
  - On out_ready, return to IDLE.
- Inputs are ignored outside IDLE; in_data does not need to stay stable after acceptance.
- Arithmetic:
  - Digits are unsigned 4 bits; the add-3 result never exceeds 4'b1100.
  - Unused upper digits read 0.
  - No leading-zero blanking.
- Reset (any state, including mid-SHIFT):
  - State goes to IDLE; accumulator, bcd, counter, and previous-value register clear to 0.
  - out_valid=0, wrap=0. A conversion in flight is discarded and nothing is emitted.
- Reset values of outputs: in_ready=1, out_valid=0, bcd=0, wrap=0.

## Timing
- Acceptance: in_valid && in_ready on edge k.
- SHIFT occupies edges k+1 … k+bW.
- out_valid rises after edge k+bW, so latency is bW cycles from the acceptance edge.
- Result handshake on edge m (out_valid && out_ready) takes the FSM back to IDLE.
- The earliest next acceptance is edge m+1. Peak throughput is one result per bW+2 cycles.
- in_ready and out_valid are never both high.
- Backpressure: out_valid, bcd and wrap hold indefinitely while out_ready=0.
- If out_ready is already high when DONE is entered, the handshake occurs on the first DONE edge.

## Configuration
- FIB_BCD_WRAP_EN defined:
  - A bW-bit prev register (reset 0) is updated with in_data at every acceptance.
  - The wrap bit is computed at acceptance as (in_data < prev), registered, and presented with the matching bcd.
  - The first value after reset compares against 0, so it never flags.
- FIB_BCD_WRAP_EN undefined:
  - No prev register; wrap is constant 0.
  - All other behaviour is identical.

## Structure
- Shared package fib_pkg:
  - state enum fib_bcd_state_t {IDLE, SHIFT, DONE};
  - function fib_bcd_digits(int bW) returning ND;
  - BCD digit typedef logic [3:0] bcd_digit_t.
- Sub-module fib_bcd_digit: purely combinational per-digit adjust, "if ≥5 then +3". It is instantiated ND times by a generate loop.
- Storage uses the codebase's dff module (d, clk, rst, en, q) where convenient.

## Test plan
- Reset then idle, bW=4: hold rst 2 cycles → in_ready=1, out_valid=0, bcd=8'h00, wrap=0.
- bW=4, accept 13 → out_valid after exactly 4 cycles with bcd=8'h13; accept 0 → bcd=8'h00.
- bW=8, feed 1,1,2,3,5,8,13,21,34,55,89,144,233 with out_ready=1 → bcd 12'h001 … 12'h233 in order; next acceptance one cycle after each handshake.
- Backpressure, bW=8, value 144: out_ready=0 for 5 cycles → bcd=12'h144 and out_valid held, in_ready=0, in_valid pulses ignored.
- Wrap (FIB_BCD_WRAP_EN), bW=4, sequence 8,13,5 → wrap=0,0,1 with bcd 8'h08, 8'h13, 8'h05. Without the macro, wrap=0 throughout.
- Reset mid-SHIFT, bW=8, value 200: assert rst 2 cycles after acceptance → no out_valid, bcd=0; next value 55 converts to 12'h055.
